// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths and ALU opcode encodings for the ID/EX operand stage and the EX stage.
package id_ex_operand_stage_pkg;

   localparam int DATA_W  = 32;
   localparam int REG_AW  = 5;
   localparam int ALUOP_W = 4;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_OR  = 4'h3,
      ALU_XOR = 4'h4,
      ALU_SLT = 4'h5,
      ALU_SLL = 4'h6,
      ALU_SRL = 4'h7,
      ALU_LUI = 4'h8
   } alu_op_e;

endpackage

// File: rtl/id_ex_operand_stage_bypass.sv
// Per-operand bypass select: youngest producer wins (EX > MEM > WB > register file), r0 reads zero.
module operand_bypass_mux
   import id_ex_operand_stage_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  logic              ex_fwd_en,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] operand
);

   always_comb begin
      operand = rf_data;
      if (src == '0)
         operand = '0;
      else if (ex_fwd_en && ex_rd == src)
         operand = ex_data;
      else if (mem_reg_write && mem_rd == src)
         operand = mem_data;
      // The register file writes on the edge, so a same-cycle WB write is not yet visible in rf_data.
      else if (wb_reg_write && wb_rd == src)
         operand = wb_data;
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypassing, load-use bubble insertion and a stall counter.
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic               id_use_rs,
   input  logic               id_use_rt,
   input  logic [REG_AW-1:0]  id_rd,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [DATA_W-1:0]  rf_reg1_data,
   input  logic [DATA_W-1:0]  rf_reg2_data,
   input  logic [DATA_W-1:0]  ex_result,
   input  logic [REG_AW-1:0]  mem_rd,
   input  logic               mem_reg_write,
   input  logic [DATA_W-1:0]  mem_data,
   input  logic [REG_AW-1:0]  wb_rd,
   input  logic               wb_reg_write,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               flush,
   input  logic               hold,
   output logic               stall,
   output logic               idex_valid,
   output logic               idex_reg_write,
   output logic               idex_mem_read,
   output logic               idex_mem_write,
   output logic [DATA_W-1:0]  idex_rs_val,
   output logic [DATA_W-1:0]  idex_rt_val,
   output logic [REG_AW-1:0]  idex_rd,
   output logic [ALUOP_W-1:0] idex_alu_op,
   output logic [DATA_W-1:0]  idex_imm,
   output logic [CNT_W-1:0]   stall_count
);

   logic              ex_fwd_en;
   logic              hazard;
   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;

   // A load in EX has no result yet; its data only becomes available from MEM.
   assign ex_fwd_en = idex_valid & idex_reg_write & ~idex_mem_read;

   assign hazard = id_valid & idex_valid & idex_mem_read & (idex_rd != '0) &
                   ((id_use_rs & (idex_rd == id_rs)) | (id_use_rt & (idex_rd == id_rt)));

   assign stall = ~rst & ~flush & hazard;

   operand_bypass_mux u_rs_mux (
      .src           (id_rs),
      .ex_fwd_en     (ex_fwd_en),
      .ex_rd         (idex_rd),
      .ex_data       (ex_result),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .rf_data       (rf_reg1_data),
      .operand       (rs_fwd)
   );

   operand_bypass_mux u_rt_mux (
      .src           (id_rt),
      .ex_fwd_en     (ex_fwd_en),
      .ex_rd         (idex_rd),
      .ex_data       (ex_result),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .rf_data       (rf_reg2_data),
      .operand       (rt_fwd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_valid     <= 1'b0;
         idex_reg_write <= 1'b0;
         idex_mem_read  <= 1'b0;
         idex_mem_write <= 1'b0;
         idex_rs_val    <= '0;
         idex_rt_val    <= '0;
         idex_rd        <= '0;
         idex_alu_op    <= '0;
         idex_imm       <= '0;
         stall_count    <= '0;
      end else if (!hold) begin
         idex_rs_val <= rs_fwd;
         idex_rt_val <= rt_fwd;
         idex_rd     <= id_rd;
         idex_alu_op <= id_alu_op;
         idex_imm    <= id_imm;
         if (flush || hazard) begin
            idex_valid     <= 1'b0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
            if (!flush && stall_count != '1)
               stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            idex_valid     <= id_valid;
            idex_reg_write <= id_reg_write & id_valid;
            idex_mem_read  <= id_mem_read & id_valid;
            idex_mem_write <= id_mem_write & id_valid;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: bypass priority, load-use bubbles, flush and hold.
module tb_id_ex_operand_stage;
   import id_ex_operand_stage_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               id_valid;
   logic [REG_AW-1:0]  id_rs, id_rt, id_rd;
   logic               id_use_rs, id_use_rt;
   logic               id_reg_write, id_mem_read, id_mem_write;
   logic [ALUOP_W-1:0] id_alu_op;
   logic [DATA_W-1:0]  id_imm;
   logic [DATA_W-1:0]  rf_reg1_data, rf_reg2_data, ex_result;
   logic [REG_AW-1:0]  mem_rd, wb_rd;
   logic               mem_reg_write, wb_reg_write;
   logic [DATA_W-1:0]  mem_data, wb_data;
   logic               flush, hold;
   logic               stall;
   logic               idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
   logic [DATA_W-1:0]  idex_rs_val, idex_rt_val, idex_imm;
   logic [REG_AW-1:0]  idex_rd;
   logic [ALUOP_W-1:0] idex_alu_op;
   logic [31:0]        stall_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(.CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_use_rs      (id_use_rs),
      .id_use_rt      (id_use_rt),
      .id_rd          (id_rd),
      .id_reg_write   (id_reg_write),
      .id_mem_read    (id_mem_read),
      .id_mem_write   (id_mem_write),
      .id_alu_op      (id_alu_op),
      .id_imm         (id_imm),
      .rf_reg1_data   (rf_reg1_data),
      .rf_reg2_data   (rf_reg2_data),
      .ex_result      (ex_result),
      .mem_rd         (mem_rd),
      .mem_reg_write  (mem_reg_write),
      .mem_data       (mem_data),
      .wb_rd          (wb_rd),
      .wb_reg_write   (wb_reg_write),
      .wb_data        (wb_data),
      .flush          (flush),
      .hold           (hold),
      .stall          (stall),
      .idex_valid     (idex_valid),
      .idex_reg_write (idex_reg_write),
      .idex_mem_read  (idex_mem_read),
      .idex_mem_write (idex_mem_write),
      .idex_rs_val    (idex_rs_val),
      .idex_rt_val    (idex_rt_val),
      .idex_rd        (idex_rd),
      .idex_alu_op    (idex_alu_op),
      .idex_imm       (idex_imm),
      .stall_count    (stall_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw,
                         input logic [3:0] op, input logic [31:0] imm);
      id_valid = v;   id_rs = rs;  id_use_rs = urs; id_rt = rt; id_use_rt = urt;
      id_rd = rd;     id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
      id_alu_op = op; id_imm = imm;
   endtask

   task automatic set_mem(input logic w, input logic [4:0] rd, input logic [31:0] d);
      mem_reg_write = w; mem_rd = rd; mem_data = d;
   endtask

   task automatic set_wb(input logic w, input logic [4:0] rd, input logic [31:0] d);
      wb_reg_write = w; wb_rd = rd; wb_data = d;
   endtask

   initial begin
      rst = 1'b1; hold = 1'b1; flush = 1'b1;
      set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1, ALU_SUB, 32'h1234);
      rf_reg1_data = 32'h5; rf_reg2_data = 32'h6; ex_result = 32'h0;
      set_mem(0, 5'd0, 32'h0);
      set_wb(0, 5'd0, 32'h0);

      // Reset overrides hold and flush
      tick(); tick();
      check("rst_valid", {31'b0, idex_valid}, 32'd0);
      check("rst_ctrl", {29'b0, idex_reg_write, idex_mem_read, idex_mem_write}, 32'd0);
      check("rst_rs_val", idex_rs_val, 32'h0);
      check("rst_imm", idex_imm, 32'h0);
      check("rst_cnt", stall_count, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);

      // add r3 <- r1, r2 from the register file
      rst = 1'b0; hold = 1'b0; flush = 1'b0;
      set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, ALU_ADD, 32'h10);
      tick();
      check("add_valid", {31'b0, idex_valid}, 32'd1);
      check("add_rs_rf", idex_rs_val, 32'h5);
      check("add_rt_rf", idex_rt_val, 32'h6);
      check("add_rd", {27'b0, idex_rd}, 32'd3);
      check("add_op_imm", {idex_alu_op, idex_imm[27:0]}, {ALU_ADD, 28'h10});

      // EX bypass on rs
      set_id(1, 5'd3, 1, 5'd0, 1, 5'd6, 1, 0, 0, ALU_OR, 32'h0);
      rf_reg1_data = 32'h11; ex_result = 32'hAB;
      tick();
      check("ex_fwd_rs", idex_rs_val, 32'hAB);
      check("rt_r0", idex_rt_val, 32'h0);

      // rs=r0 reads zero; rt=r6 hits both EX and MEM, EX wins
      set_id(1, 5'd0, 1, 5'd6, 1, 5'd0, 0, 0, 0, ALU_ADD, 32'h0);
      rf_reg1_data = 32'h99; ex_result = 32'hAB;
      set_mem(1, 5'd6, 32'h44);
      tick();
      check("r0_zero", idex_rs_val, 32'h0);
      check("ex_over_mem", idex_rt_val, 32'hAB);

      // MEM beats WB, then WB, then register file
      set_id(1, 5'd7, 1, 5'd5, 1, 5'd0, 0, 0, 0, ALU_ADD, 32'h0);
      rf_reg1_data = 32'h70; rf_reg2_data = 32'h55;
      set_mem(1, 5'd5, 32'h22);
      set_wb(1, 5'd5, 32'h33);
      tick();
      check("mem_over_wb", idex_rt_val, 32'h22);
      check("rs_no_match", idex_rs_val, 32'h70);
      mem_reg_write = 1'b0;
      tick();
      check("wb_fwd", idex_rt_val, 32'h33);
      wb_reg_write = 1'b0;
      // lw r4 enters ID here
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, ALU_ADD, 32'h8);
      tick();
      check("lw_mem_read", {31'b0, idex_mem_read}, 32'd1);

      // Load-use on rs: one bubble
      set_id(1, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0, 0, ALU_ADD, 32'h0);
      rf_reg1_data = 32'h1;
      #1;
      check("lu_stall", {31'b0, stall}, 32'd1);
      tick();
      check("lu_bubble", {30'b0, idex_valid, idex_reg_write}, 32'd0);
      check("lu_cnt", stall_count, 32'd1);
      check("lu_stall_drop", {31'b0, stall}, 32'd0);
      set_mem(1, 5'd4, 32'h77);
      tick();
      check("lu_mem_fwd", idex_rs_val, 32'h77);
      check("lu_resume", {31'b0, idex_valid}, 32'd1);

      // Store with both operands on the same load: single stall
      set_mem(0, 5'd0, 32'h0);
      set_id(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0, ALU_ADD, 32'h0);
      tick();
      set_id(1, 5'd9, 1, 5'd9, 1, 5'd0, 0, 0, 1, ALU_ADD, 32'h4);
      #1;
      check("dual_stall", {31'b0, stall}, 32'd1);
      tick();
      check("dual_cnt", stall_count, 32'd2);
      check("dual_stall_once", {31'b0, stall}, 32'd0);
      set_mem(1, 5'd9, 32'h99);
      tick();
      check("dual_rs", idex_rs_val, 32'h99);
      check("dual_rt", idex_rt_val, 32'h99);
      check("dual_store", {31'b0, idex_mem_write}, 32'd1);

      // Flush during a hazard: no stall, bubble, counter unchanged
      set_mem(0, 5'd0, 32'h0);
      set_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1, 0, ALU_ADD, 32'h0);
      tick();
      set_id(1, 5'd1, 1, 5'd10, 1, 5'd0, 0, 0, 1, ALU_ADD, 32'h0);
      flush = 1'b1;
      #1;
      check("flush_stall", {31'b0, stall}, 32'd0);
      tick();
      flush = 1'b0;
      check("flush_bubble", {31'b0, idex_valid | idex_mem_write}, 32'd0);
      check("flush_cnt", stall_count, 32'd2);

      // Store whose rt alone depends on the load
      set_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1, 0, ALU_ADD, 32'h0);
      tick();
      set_id(1, 5'd1, 1, 5'd10, 1, 5'd0, 0, 0, 1, ALU_ADD, 32'h0);
      #1;
      check("st_rt_stall", {31'b0, stall}, 32'd1);
      tick();
      check("st_rt_cnt", stall_count, 32'd3);

      // Load into r0 never stalls
      set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, ALU_ADD, 32'h0);
      tick();
      set_id(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0, ALU_ADD, 32'h0);
      #1;
      check("r0_load_nostall", {31'b0, stall}, 32'd0);
      tick();
      check("r0_load_valid", {31'b0, idex_valid}, 32'd1);

      // Hold freezes idex_* while ID changes
      set_id(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 0, 0, ALU_OR, 32'hCAFE);
      rf_reg1_data = 32'h123;
      tick();
      check("pre_hold_rs", idex_rs_val, 32'h123);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 5'd1, 1, 5'd0, 0, 5'(13 + i), 0, 1, 1, ALU_XOR, 32'hBEE0 + i);
         rf_reg1_data = 32'h400 + i;
         tick();
         check("hold_rd", {27'b0, idex_rd}, 32'd12);
         check("hold_rs", idex_rs_val, 32'h123);
         check("hold_imm", idex_imm, 32'hCAFE);
      end
      check("hold_ctrl", {28'b0, idex_valid, idex_reg_write, idex_mem_read, idex_mem_write}, 32'b1100);
      hold = 1'b0;
      tick();
      check("release_rd", {27'b0, idex_rd}, 32'd15);
      check("release_rs", idex_rs_val, 32'h402);
      check("release_imm", idex_imm, 32'hBEE2);
      check("release_op", {28'b0, idex_alu_op}, {28'b0, ALU_XOR});

      // Invalid ID instruction gates its control bits
      set_id(0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 1, ALU_ADD, 32'h0);
      tick();
      check("invalid_gate", {28'b0, idex_valid, idex_reg_write, idex_mem_read, idex_mem_write}, 32'd0);
      check("final_cnt", stall_count, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
